pe_result_unloader: RTL and testbench

PE_RESULT_UNLOADER -- requirements
Module: pe_result_unloader

---
 rtl/pe_result_unloader.sv | 166 ++++++++++++++++
 tb/tb_pe_result_unloader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pe_result_unloader.sv
// Snapshots a flattened PE result array and streams it out one byte at a time with a valid/ready handshake.
// Optional trailing XOR checksum byte when PE_UNLOAD_CHECKSUM_EN is defined.
module pe_result_unloader #(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [M*N*OUTPUT_WIDTH-1:0]     data_in,
  input  logic                            start,
  input  logic                            out_ready,
  output logic [7:0]                      out_byte,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int NPE   = M * N;
  localparam int BPP   = OUTPUT_WIDTH / 8;
  localparam int TOTAL = NPE * OUTPUT_WIDTH;
  localparam int PW    = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(NPE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BPP - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_r;
  logic [TOTAL-1:0] snap_r;
  logic [PW-1:0]    p_r;
  logic [BW-1:0]    b_r;
  logic [7:0]       out_byte_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
`ifdef PE_UNLOAD_CHECKSUM_EN
  logic [7:0]       csum_r;
  logic             chk_r;
`endif

  logic [PW-1:0]    p_nxt_s;
  logic [BW-1:0]    b_nxt_s;
  logic             last_data_s;

  function automatic logic [7:0] byte_at(input logic [TOTAL-1:0] snap,
                                         input logic [PW-1:0]    p,
                                         input logic [BW-1:0]    b);
    int idx;
    idx = int'(p) * BPP + int'(b);
    return snap[idx*8 +: 8];
  endfunction

  // Next (PE, byte) position in row-major, LSB-first order.
  always_comb begin
    p_nxt_s     = p_r;
    b_nxt_s     = b_r;
    last_data_s = (p_r == P_LAST) && (b_r == B_LAST);
    if (b_r == B_LAST) begin
      b_nxt_s = '0;
      p_nxt_s = p_r + P_ONE;
    end else begin
      b_nxt_s = b_r + B_ONE;
      p_nxt_s = p_r;
    end
  end

  // Unload sequencer; every output is a flop so it is glitch-free and held during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      snap_r      <= '0;
      p_r         <= '0;
      b_r         <= '0;
      out_byte_r  <= 8'h00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef PE_UNLOAD_CHECKSUM_EN
      csum_r      <= 8'h00;
      chk_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            snap_r      <= data_in;
            p_r         <= '0;
            b_r         <= '0;
            out_byte_r  <= data_in[7:0];
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_SEND;
`ifdef PE_UNLOAD_CHECKSUM_EN
            csum_r      <= 8'h00;
            chk_r       <= 1'b0;
`endif
          end else begin
            out_byte_r  <= 8'h00;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        S_SEND: begin
          if (out_ready) begin
`ifdef PE_UNLOAD_CHECKSUM_EN
            if (chk_r) begin
              state_r     <= S_FIN;
              out_byte_r  <= 8'h00;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else if (last_data_s) begin
              // Checksum covers every data byte, including the one leaving now.
              chk_r      <= 1'b1;
              out_byte_r <= csum_r ^ out_byte_r;
            end else begin
              csum_r     <= csum_r ^ out_byte_r;
              p_r        <= p_nxt_s;
              b_r        <= b_nxt_s;
              out_byte_r <= byte_at(snap_r, p_nxt_s, b_nxt_s);
            end
`else
            if (last_data_s) begin
              state_r     <= S_FIN;
              out_byte_r  <= 8'h00;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              p_r        <= p_nxt_s;
              b_r        <= b_nxt_s;
              out_byte_r <= byte_at(snap_r, p_nxt_s, b_nxt_s);
            end
`endif
          end else begin
            state_r <= S_SEND;
          end
        end
        S_FIN: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          out_byte_r  <= 8'h00;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_byte  = out_byte_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_pe_result_unloader.sv
// Randomized self-checking bench for pe_result_unloader against a byte-queue reference model.
// Honours PE_UNLOAD_CHECKSUM_EN to expect the trailing XOR byte.
module tb_pe_result_unloader;

  localparam int M   = 2;
  localparam int N   = 2;
  localparam int W   = 32;
  localparam int TOT = M * N * W;
  localparam int NB  = TOT / 8;
`ifdef PE_UNLOAD_CHECKSUM_EN
  localparam int NBT = NB + 1;
`else
  localparam int NBT = NB;
`endif

  logic           clk;
  logic           rst_n;
  logic [TOT-1:0] data_in;
  logic           start;
  logic           out_ready;
  logic [7:0]     out_byte;
  logic           out_valid;
  logic           busy;
  logic           done;

  int n_checks;
  int n_fail;
  logic [7:0] rx [0:NBT-1];

  pe_result_unloader #(.M(M), .N(N), .OUTPUT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .start(start), .out_ready(out_ready),
    .out_byte(out_byte), .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_busy"},  32'(busy),      32'd0);
    check_val({tag, "_done"},  32'(done),      32'd0);
    check_val({tag, "_byte"},  32'(out_byte),  32'd0);
  endtask

  // mode 0: ready always high, 1: 1,0,0,1 pattern, 2: random; disturb changes data_in and re-pulses start.
  task automatic run_unload(input logic [TOT-1:0] d, input int mode, input bit disturb);
    logic [7:0] exp_q [$];
    logic [7:0] cs;
    logic [7:0] prev_byte;
    bit         prev_stall;
    int         idx;
    int         cyc;
    exp_q = {};
    cs = 8'h00;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(d[k*8 +: 8]);
      cs = cs ^ d[k*8 +: 8];
    end
`ifdef PE_UNLOAD_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    @(negedge clk);
    data_in   = d;
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (disturb) data_in = '1;
    idx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_byte = 8'h00;
    while (idx < exp_q.size() && cyc < 2000) begin
      check_val("valid", 32'(out_valid), 32'd1);
      check_val("busy", 32'(busy), 32'd1);
      check_val("done_early", 32'(done), 32'd0);
      if (prev_stall) check_val("stall_hold", 32'(out_byte), 32'(prev_byte));
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (disturb && idx == 3) ? 1'b1 : 1'b0;
      if (out_ready) begin
        check_val("byte", 32'(out_byte), 32'(exp_q[idx]));
        rx[idx] = out_byte;
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_byte = out_byte;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) check_val("timeout", 32'd1, 32'd0);
    out_ready = 1'($urandom_range(0, 1));
    // FIN cycle: start here must be ignored.
    start = 1'b1;
    check_val("fin_done", 32'(done), 32'd1);
    check_val("fin_valid", 32'(out_valid), 32'd0);
    check_val("fin_busy", 32'(busy), 32'd0);
    check_val("fin_byte", 32'(out_byte), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_idle("post_fin");
    @(negedge clk);
    check_idle("fin_start_ignored");
  endtask

  logic [TOT-1:0] dir_d;
  logic [7:0]     tab [0:15];
  logic [TOT-1:0] rd;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    dir_d = {32'hDDEEFF01, 32'h99AABBCC, 32'h55667788, 32'h11223344};
    tab = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
            8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h01, 8'hFF, 8'hEE, 8'hDD};
    #1;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    run_unload(dir_d, 0, 1'b0);
    for (int k = 0; k < 16; k++) check_val("dir_table", 32'(rx[k]), 32'(tab[k]));
`ifdef PE_UNLOAD_CHECKSUM_EN
    check_val("dir_csum", 32'(rx[NB]), 32'h01);
`endif
    run_unload(dir_d, 1, 1'b0);
    for (int k = 0; k < 16; k++) check_val("stall_table", 32'(rx[k]), 32'(tab[k]));
    run_unload(dir_d, 0, 1'b1);
    for (int k = 0; k < 16; k++) check_val("snap_table", 32'(rx[k]), 32'(tab[k]));

    // Reset after the 5th byte is accepted.
    @(negedge clk);
    data_in   = dir_d;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("no_done_after_abort");
    end
    run_unload(dir_d, 2, 1'b0);
    check_val("restart_first", 32'(rx[0]), 32'h44);

    for (int r = 0; r < 8; r++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_unload(rd, r % 3, (r % 4) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
